// File: rtl/io_controller.sv
// io_controller: memory-mapped I/O stage for the single-cycle datapath.
// Synchronises and debounces board switches/keys, latches sticky key-press
// events, holds LED and 7-segment registers written by stores, and returns
// combinational read data for the addressed register.
module io_controller #(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KEYEVT     = 32'hF0000018
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrData,
  input  logic             wrEn,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic             isIo,
  output logic [DBITS-1:0] rdData,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  // Debounced inputs are kept in one vector: switches in [9:0], keys in [13:10].
  localparam int NSW  = 10;
  localparam int NKEY = 4;
  localparam int NIN  = NSW + NKEY;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NSW-1:0]           sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [NKEY-1:0]          key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [NIN-1:0]           deb_q, deb_d;
  logic [NIN-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [NKEY-1:0]          evt_q, evt_d;
  logic [15:0]              hex_q, hex_d;
  logic [9:0]               ledr_q, ledr_d;
  logic [7:0]               ledg_q, ledg_d;

  logic [NIN-1:0]           sync_in;
  logic [NKEY-1:0]          key_rise;
  logic [NKEY-1:0]          evt_clr;
  logic                     wr_hex, wr_ledr, wr_ledg, wr_evt;
  logic                     unused_wr_hi;

  // Only the low 16 store-data bits can reach any register.
  assign unused_wr_hi = ^wrData[DBITS-1:16];

  // 7-segment encoding, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Two-flop synchronisers; keys are active-low so the pressed level is inverted.
  always_comb begin
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
    key_s1_d = KEY;
    key_s2_d = key_s1_q;
    sync_in  = {~key_s2_q, sw_s2_q};
  end

  // Debounce: a bit must disagree with its debounced value for
  // DEBOUNCE_CYCLES consecutive cycles before the debounced value follows it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (sync_in[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync_in[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Store decode, sticky key events (set beats clear) and output registers.
  always_comb begin
    wr_hex   = wrEn && (addr == ADDR_HEX);
    wr_ledr  = wrEn && (addr == ADDR_LEDR);
    wr_ledg  = wrEn && (addr == ADDR_LEDG);
    wr_evt   = wrEn && (addr == ADDR_KEYEVT);
    key_rise = deb_d[NIN-1 -: NKEY] & ~deb_q[NIN-1 -: NKEY];
    evt_clr  = wr_evt ? wrData[NKEY-1:0] : '0;
    evt_d    = (evt_q & ~evt_clr) | key_rise;
    hex_d    = wr_hex  ? wrData[15:0] : hex_q;
    ledr_d   = wr_ledr ? wrData[9:0]  : ledr_q;
    ledg_d   = wr_ledg ? wrData[7:0]  : ledg_q;
  end

  // State registers; reset leaves keys in the released (high) state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      deb_q    <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      hex_q    <= '0;
      ledr_q   <= '0;
      ledg_q   <= '0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
    end
  end

  // Combinational read mux; registers read their pre-edge values.
  always_comb begin
    rdData = '0;
    isIo   = 1'b0;
    case (addr)
      ADDR_HEX: begin
        rdData = DBITS'(hex_q);
        isIo   = 1'b1;
      end
      ADDR_LEDR: begin
        rdData = DBITS'(ledr_q);
        isIo   = 1'b1;
      end
      ADDR_LEDG: begin
        rdData = DBITS'(ledg_q);
        isIo   = 1'b1;
      end
      ADDR_KEY: begin
        rdData = DBITS'(deb_q[NIN-1 -: NKEY]);
        isIo   = 1'b1;
      end
      ADDR_SW: begin
        rdData = DBITS'(deb_q[NSW-1:0]);
        isIo   = 1'b1;
      end
      ADDR_KEYEVT: begin
        rdData = DBITS'(evt_q);
        isIo   = 1'b1;
      end
      default: begin
        rdData = '0;
        isIo   = 1'b0;
      end
    endcase
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;
  assign HEX0 = seg7(hex_q[3:0]);
  assign HEX1 = seg7(hex_q[7:4]);
  assign HEX2 = seg7(hex_q[11:8]);
  assign HEX3 = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_io_controller.sv
// Testbench for io_controller with a short debounce window.
module tb_io_controller;

  localparam int D = 4;
  localparam logic [31:0] A_HEX    = 32'hF0000000;
  localparam logic [31:0] A_LEDR   = 32'hF0000004;
  localparam logic [31:0] A_LEDG   = 32'hF0000008;
  localparam logic [31:0] A_KEY    = 32'hF0000010;
  localparam logic [31:0] A_SW     = 32'hF0000014;
  localparam logic [31:0] A_KEYEVT = 32'hF0000018;
  localparam logic [31:0] A_BAD    = 32'hF000001C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wrData, rdData;
  logic        wrEn, isIo;
  logic [9:0]  SW, LEDR;
  logic [3:0]  KEY;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;

  io_controller #(.DBITS(32), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .wrEn(wrEn),
    .SW(SW), .KEY(KEY), .isIo(isIo), .rdData(rdData), .LEDR(LEDR), .LEDG(LEDG),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  // Reference model: inputs are debounced by a stability window over the
  // sampled history ({pressed keys, switches} per clock edge).
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [13:0] hist [$];
  logic [13:0] m_deb;
  logic [3:0]  m_evt;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a)
      A_HEX:    return {16'b0, m_hex};
      A_LEDR:   return {22'b0, m_ledr};
      A_LEDG:   return {24'b0, m_ledg};
      A_KEY:    return {28'b0, m_deb[13:10]};
      A_SW:     return {22'b0, m_deb[9:0]};
      A_KEYEVT: return {28'b0, m_evt};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic model_isio(input logic [31:0] a);
    return (a == A_HEX) || (a == A_LEDR) || (a == A_LEDG) ||
           (a == A_KEY) || (a == A_SW) || (a == A_KEYEVT);
  endfunction

  task automatic model_reset();
    m_deb = '0; m_evt = '0; m_hex = '0; m_ledr = '0; m_ledg = '0;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(14'h0);
  endtask

  // One clock edge: the model sees the inputs being driven into that edge.
  // A debounced bit flips at edge m when the D samples taken at edges
  // m-1-D .. m-2 all hold the opposite level (two synchroniser stages).
  task automatic tick();
    logic [13:0] smp, nd;
    logic        w_en, all_opp;
    logic [31:0] w_a, w_d;
    logic [3:0]  clr, rise;
    smp  = {~KEY, SW};
    w_en = wrEn; w_a = addr; w_d = wrData;
    @(posedge clk);
    hist.push_back(smp);
    while (hist.size() > D + 2) void'(hist.pop_front());
    nd = m_deb;
    for (int b = 0; b < 14; b++) begin
      all_opp = 1'b1;
      for (int j = 0; j < D; j++) if (hist[j][b] == m_deb[b]) all_opp = 1'b0;
      if (all_opp) nd[b] = ~m_deb[b];
    end
    rise  = nd[13:10] & ~m_deb[13:10];
    clr   = (w_en && w_a == A_KEYEVT) ? w_d[3:0] : 4'h0;
    m_evt = (m_evt & ~clr) | rise;
    if (w_en && w_a == A_HEX)  m_hex  = w_d[15:0];
    if (w_en && w_a == A_LEDR) m_ledr = w_d[9:0];
    if (w_en && w_a == A_LEDG) m_ledg = w_d[7:0];
    m_deb = nd;
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; wrEn = 1'b0;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic test_reset();
    KEY = 4'b0111;
    store(A_LEDR, 32'h2AA);
    store(A_LEDG, 32'h5C);
    store(A_HEX, 32'h1234);
    repeat (D + 3) tick();
    rd(A_KEY);
    checks++; if (rdData !== 32'h8) begin errors++; $display("FAIL pre_reset_key: got %h expected %h", rdData, 32'h8); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (LEDR !== 10'h0) begin errors++; $display("FAIL reset_ledr: got %h expected 000", LEDR); end
    checks++; if (LEDG !== 8'h0) begin errors++; $display("FAIL reset_ledg: got %h expected 00", LEDG); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'h40}}) begin errors++; $display("FAIL reset_hex: got %h %h %h %h expected 40 each", HEX3, HEX2, HEX1, HEX0); end
    rd(A_KEY);
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL reset_key_read: got %h expected 0", rdData); end
    KEY = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_hex();
    logic [31:0] d;
    store(A_HEX, 32'h00001A2F);
    checks++; if (HEX0 !== 7'h0E) begin errors++; $display("FAIL hex0: got %h expected 0e", HEX0); end
    checks++; if (HEX1 !== 7'h24) begin errors++; $display("FAIL hex1: got %h expected 24", HEX1); end
    checks++; if (HEX2 !== 7'h08) begin errors++; $display("FAIL hex2: got %h expected 08", HEX2); end
    checks++; if (HEX3 !== 7'h79) begin errors++; $display("FAIL hex3: got %h expected 79", HEX3); end
    rd(A_HEX);
    checks++; if (rdData !== 32'h00001A2F) begin errors++; $display("FAIL hex_read: got %h expected 00001a2f", rdData); end
    checks++; if (isIo !== 1'b1) begin errors++; $display("FAIL hex_isio: got %b expected 1", isIo); end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      store(A_HEX, d);
      checks++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {seg_tab[d[15:12]], seg_tab[d[11:8]], seg_tab[d[7:4]], seg_tab[d[3:0]]}) begin
        errors++; $display("FAIL hex_rand: data %h got %h %h %h %h", d, HEX3, HEX2, HEX1, HEX0);
      end
      rd(A_HEX);
      checks++; if (rdData !== {16'b0, d[15:0]}) begin errors++; $display("FAIL hex_rand_read: got %h expected %h", rdData, {16'b0, d[15:0]}); end
    end
  endtask

  task automatic test_debounce_sw();
    logic [31:0] exp;
    addr = A_SW; wrEn = 1'b0;
    SW = 10'h155;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = (i >= 5) ? 32'h155 : 32'h0;
      checks++; if (rdData !== exp) begin errors++; $display("FAIL sw_latency edge N+%0d: got %h expected %h", i, rdData, exp); end
    end
    SW = 10'h0;
    repeat (3) begin
      tick();
      checks++; if (rdData !== 32'h155) begin errors++; $display("FAIL sw_pulse: got %h expected 155", rdData); end
    end
    SW = 10'h155;
    repeat (6) begin
      tick();
      checks++; if (rdData !== 32'h155) begin errors++; $display("FAIL sw_pulse_after: got %h expected 155", rdData); end
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) SW = 10'($urandom);
      else if ($urandom_range(0, 3) == 0) SW = SW ^ (10'h1 << $urandom_range(0, 9));
      tick();
      checks++; if (rdData !== model_rd(A_SW)) begin errors++; $display("FAIL sw_rand cycle %0d: got %h expected %h", i, rdData, model_rd(A_SW)); end
    end
    repeat (D + 3) tick();
  endtask

  task automatic test_key_events();
    KEY = 4'b1101;
    repeat (D + 3) tick();
    rd(A_KEY);
    checks++; if (rdData !== 32'h2) begin errors++; $display("FAIL key_read: got %h expected 2", rdData); end
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h2) begin errors++; $display("FAIL keyevt_set: got %h expected 2", rdData); end
    KEY = 4'hF;
    repeat (D + 3) tick();
    rd(A_KEY);
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL key_release: got %h expected 0", rdData); end
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h2) begin errors++; $display("FAIL keyevt_sticky: got %h expected 2", rdData); end
    store(A_KEYEVT, 32'h2);
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL keyevt_clear: got %h expected 0", rdData); end
    // Press again and clear on exactly the edge where the key registers.
    KEY = 4'b1101;
    for (int i = 0; i <= D + 1; i++) begin
      if (i == D + 1) begin addr = A_KEYEVT; wrData = 32'h2; wrEn = 1'b1; end
      tick();
      wrEn = 1'b0;
      if (i == D) begin
        rd(A_KEYEVT);
        checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL keyevt_before_rise: got %h expected 0", rdData); end
      end
    end
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h2) begin errors++; $display("FAIL keyevt_set_wins: got %h expected 2", rdData); end
    checks++; if (rdData !== model_rd(A_KEYEVT)) begin errors++; $display("FAIL keyevt_set_wins_model: got %h expected %h", rdData, model_rd(A_KEYEVT)); end
    KEY = 4'hF;
    repeat (D + 3) tick();
    store(A_KEYEVT, 32'hF);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        addr = A_KEYEVT; wrData = $urandom; wrEn = 1'b1;
      end
      tick();
      wrEn = 1'b0;
      rd(A_KEY);
      checks++; if (rdData !== model_rd(A_KEY)) begin errors++; $display("FAIL key_rand cycle %0d: got %h expected %h", i, rdData, model_rd(A_KEY)); end
      rd(A_KEYEVT);
      checks++; if (rdData !== model_rd(A_KEYEVT)) begin errors++; $display("FAIL keyevt_rand cycle %0d: got %h expected %h", i, rdData, model_rd(A_KEYEVT)); end
    end
    KEY = 4'hF;
    repeat (D + 3) tick();
    store(A_KEYEVT, 32'hF);
  endtask

  task automatic test_leds();
    logic [31:0] a;
    store(A_LEDR, 32'hFFFFFFFF);
    store(A_LEDG, 32'h1AB);
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("FAIL ledr_write: got %h expected 3ff", LEDR); end
    checks++; if (LEDG !== 8'hAB) begin errors++; $display("FAIL ledg_write: got %h expected ab", LEDG); end
    rd(A_LEDG);
    checks++; if (rdData !== 32'hAB) begin errors++; $display("FAIL ledg_read: got %h expected ab", rdData); end
    addr = A_LEDR; wrData = 32'h155; wrEn = 1'b1;
    #1;
    checks++; if (rdData !== 32'h3FF) begin errors++; $display("FAIL ledr_read_during_write: got %h expected 3ff", rdData); end
    tick();
    wrEn = 1'b0;
    checks++; if (LEDR !== 10'h155) begin errors++; $display("FAIL ledr_after_write: got %h expected 155", LEDR); end
    addr = A_BAD; wrData = 32'hFFFFFFFF; wrEn = 1'b1;
    #1;
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", rdData); end
    checks++; if (isIo !== 1'b0) begin errors++; $display("FAIL unmapped_isio: got %b expected 0", isIo); end
    tick();
    wrEn = 1'b0;
    checks++; if (LEDR !== 10'h155 || LEDG !== 8'hAB) begin errors++; $display("FAIL unmapped_no_change: got %h %h expected 155 ab", LEDR, LEDG); end
    rd(A_HEX);
    checks++; if (rdData !== model_rd(A_HEX)) begin errors++; $display("FAIL unmapped_hex_kept: got %h expected %h", rdData, model_rd(A_HEX)); end
    store(A_SW, 32'hFFFFFFFF);
    rd(A_SW);
    checks++; if (rdData !== model_rd(A_SW)) begin errors++; $display("FAIL sw_write_ignored: got %h expected %h", rdData, model_rd(A_SW)); end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: a = A_HEX;
        1: a = A_LEDR;
        2: a = A_LEDG;
        3: a = A_KEY;
        4: a = A_SW;
        5: a = A_KEYEVT;
        6: a = A_BAD;
        7: a = A_LEDR + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      addr = a; wrData = $urandom; wrEn = 1'($urandom_range(0, 1));
      #1;
      checks++; if (isIo !== model_isio(a)) begin errors++; $display("FAIL rand_isio addr %h: got %b expected %b", a, isIo, model_isio(a)); end
      checks++; if (rdData !== model_rd(a)) begin errors++; $display("FAIL rand_read addr %h: got %h expected %h", a, rdData, model_rd(a)); end
      tick();
      wrEn = 1'b0;
      checks++;
      if (LEDR !== m_ledr || LEDG !== m_ledg ||
          {HEX3, HEX2, HEX1, HEX0} !== {seg_tab[m_hex[15:12]], seg_tab[m_hex[11:8]], seg_tab[m_hex[7:4]], seg_tab[m_hex[3:0]]}) begin
        errors++; $display("FAIL rand_outputs: got %h %h hexreg-model %h", LEDR, LEDG, m_hex);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    store(A_KEYEVT, 32'hF);
    KEY = 4'b1110;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
    #1;
    KEY = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    addr = A_KEY;
    repeat (D + 4) begin
      tick();
      checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL mid_reset_key: got %h expected 0", rdData); end
    end
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL mid_reset_evt: got %h expected 0", rdData); end
    KEY = 4'b1110;
    addr = A_KEY;
    repeat (D + 1) tick();
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL new_press_early: got %h expected 0", rdData); end
    tick();
    checks++; if (rdData !== 32'h1) begin errors++; $display("FAIL new_press_registered: got %h expected 1", rdData); end
    rd(A_KEYEVT);
    checks++; if (rdData !== 32'h1) begin errors++; $display("FAIL new_press_evt: got %h expected 1", rdData); end
  endtask

  initial begin
    reset = 1'b1; wrEn = 1'b0; addr = 32'h0; wrData = 32'h0; SW = 10'h0; KEY = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_hex();
    test_debounce_sw();
    test_key_events();
    test_leds();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
